// File: rtl/cmos_logic_pipe.sv
// Registered bitwise reduction unit: NUM_IN operands reduced under a selectable
// gate function, two pipeline stages with valid/ready on both sides.
module cmos_logic_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [2:0]              out_op
);

  if (NUM_IN < 2 || NUM_IN > 8) begin : g_num_in_check
    $error("cmos_logic_pipe: NUM_IN must be in the range 2..8");
  end

  localparam logic [2:0] OP_OR      = 3'b000;
  localparam logic [2:0] OP_NOR     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_NAND    = 3'b011;
  localparam logic [2:0] OP_XOR     = 3'b100;
  localparam logic [2:0] OP_XNOR    = 3'b101;
  localparam logic [2:0] OP_ACC_OR  = 3'b110;

  logic [WIDTH-1:0] red_or;
  logic [WIDTH-1:0] red_and;
  logic [WIDTH-1:0] red_xor;
  logic [WIDTH-1:0] s1_next;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [2:0]       s1_op;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic [2:0]       s2_op;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] s2_next;

  logic s1_adv;
  logic ready_int;
  logic in_xfer;

  always_comb begin
    red_or  = '0;
    red_and = '1;
    red_xor = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
      red_and = red_and & in_data[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  // ACC_OR carries only the operand OR here; acc is merged at the s1->s2 move
  // so accumulation follows transaction order. ACC_CLR carries zero.
  always_comb begin
    s1_next = '0;
    case (op)
      OP_OR:     s1_next = red_or;
      OP_NOR:    s1_next = ~red_or;
      OP_AND:    s1_next = red_and;
      OP_NAND:   s1_next = ~red_and;
      OP_XOR:    s1_next = red_xor;
      OP_XNOR:   s1_next = ~red_xor;
      OP_ACC_OR: s1_next = red_or;
      default:   s1_next = '0;
    endcase
  end

  assign s2_next   = (s1_op == OP_ACC_OR) ? (acc | s1_data) : s1_data;
  assign s1_adv    = !s2_valid || out_ready;
  assign ready_int = !s1_valid || s1_adv;
  assign in_xfer   = in_valid && ready_int;
  assign in_ready  = rst_n && ready_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_op    <= 3'b000;
    end else begin
      s1_valid <= in_xfer || (s1_valid && !s1_adv);
      if (in_xfer) begin
        s1_data <= s1_next;
        s1_op   <= op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_op    <= 3'b000;
      acc      <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= s2_next;
        s2_op   <= s1_op;
        if (s1_op == OP_ACC_OR || s1_op == 3'b111) begin
          acc <= s2_next;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_op    = s2_op;

endmodule

// File: tb/tb_cmos_logic_pipe.sv
// Bench for cmos_logic_pipe: a NUM_IN=2 and a NUM_IN=4 instance checked against
// a per-bit counting reference model through expected-result queues.
module tb_cmos_logic_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv   [2];
  logic        irdy [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [31:0] idat [2];
  logic [2:0]  iop  [2];
  logic [2:0]  oo   [2];
  logic [7:0]  od   [2];

  typedef struct {
    logic [7:0] d;
    logic [2:0] o;
    int         c;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] macc [2];
  int         ncmp = 0;
  int         nerr = 0;
  int         cyc  = 0;
  int         in_cnt  [2];
  int         out_cnt [2];
  bit         lat_chk = 0;
  bit         thr     = 0;
  bit         bp_done = 0;
  bit         rnd_en  [2];
  bit         held    [2];
  logic [7:0] hd [2];
  logic [2:0] ho [2];

  cmos_logic_pipe #(.WIDTH(8), .NUM_IN(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(idat[0][15:0]), .op(iop[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_op(oo[0])
  );

  cmos_logic_pipe #(.WIDTH(8), .NUM_IN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(idat[1]), .op(iop[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_op(oo[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per result bit: count ones across the operands, then apply the gate rule.
  function automatic logic [7:0] model(input logic [31:0] d, input logic [2:0] o,
                                       input int n, input logic [7:0] acc);
    logic [7:0] vor, vand, vxor;
    int cnt;
    for (int b = 0; b < 8; b++) begin
      cnt = 0;
      for (int k = 0; k < n; k++) if (d[k*8+b]) cnt++;
      vor[b]  = (cnt > 0);
      vand[b] = (cnt == n);
      vxor[b] = ((cnt % 2) == 1);
    end
    case (o)
      3'd0: return vor;
      3'd1: return ~vor;
      3'd2: return vand;
      3'd3: return ~vand;
      3'd4: return vxor;
      3'd5: return ~vxor;
      3'd6: return acc | vor;
      default: return 8'h00;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [31:0] d, input logic [2:0] o,
                      input bit lit, input logic [7:0] lv);
    exp_t e;
    logic [7:0] m;
    bit ok;
    int w;
    iv[i] = 1'b1; idat[i] = d; iop[i] = o;
    ok = 0; w = 0;
    while (!ok && w < 200) begin
      @(negedge clk);
      if (irdy[i]) begin
        ok = 1;
        m = model(d, o, (i == 0) ? 2 : 4, macc[i]);
        if (o == 3'd6) macc[i] = m;
        if (o == 3'd7) macc[i] = 8'h00;
        e.d = lit ? lv : m;
        e.o = o;
        e.c = cyc;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
      end else begin
        w++;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    if (thr) chk("thr_rdy_waits", w, 0);
  endtask

  task automatic mon_pop(input int i);
    exp_t e;
    bit have;
    have = 0;
    if (i == 0) begin
      if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
    end else begin
      if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
    end
    if (!have) begin
      chk($sformatf("extra_out%0d", i), 1, 0);
    end else begin
      chk($sformatf("data%0d", i), od[i], e.d);
      chk($sformatf("op%0d", i), oo[i], e.o);
      if (lat_chk && i == 1) chk("latency", cyc - e.c, 2);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        held[i] = 0;
      end else begin
        if (iv[i] && irdy[i]) in_cnt[i]++;
        if (held[i]) begin
          chk($sformatf("stall_valid%0d", i), ov[i], 1);
          chk($sformatf("stall_data%0d", i), od[i], hd[i]);
          chk($sformatf("stall_op%0d", i), oo[i], ho[i]);
        end
        if (ov[i] && ordy[i]) begin
          out_cnt[i]++;
          mon_pop(i);
        end
        held[i] = ov[i] && !ordy[i];
        hd[i] = od[i];
        ho[i] = oo[i];
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
        if (rnd_en[i]) ordy[i] = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 0; idat[i] = '0; iop[i] = '0; ordy[i] = 1; macc[i] = '0;
      in_cnt[i] = 0; out_cnt[i] = 0; rnd_en[i] = 0;
    end
    idle(2);
    chk("rst_rdy_low", irdy[0], 0);
    chk("rst_rdy_low4", irdy[1], 0);
    #3 rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", ov[i], 0);
      chk("rst_out_data", od[i], 0);
      chk("rst_out_op", oo[i], 0);
      chk("rst_in_ready", irdy[i], 1);
    end

    // Two-operand gate functions
    send(0, 32'h0FA5, 3'd0, 1, 8'hAF);
    send(0, 32'h0FA5, 3'd2, 1, 8'h05);
    send(0, 32'h0FA5, 3'd4, 1, 8'hAA);
    iv[0] = 0;
    idle(4);

    // Four operands {FF,F0,3C,01}, inverting ops invert the whole reduction
    send(1, 32'h013CF0FF, 3'd3, 1, 8'hFF);
    send(1, 32'h013CF0FF, 3'd1, 1, 8'h00);
    send(1, 32'h013CF0FF, 3'd5, 1, 8'hCD);
    iv[1] = 0;
    idle(4);

    send(0, 32'h0001, 3'd6, 1, 8'h01);
    send(0, 32'h0080, 3'd6, 1, 8'h81);
    send(0, $urandom, 3'd7, 1, 8'h00);
    send(0, 32'h0010, 3'd6, 1, 8'h10);
    iv[0] = 0;
    idle(4);

    // Backpressure: five back-to-back ORs into a stalled output
    ordy[0] = 0;
    base = in_cnt[0];
    bp_done = 0;
    fork
      begin
        for (int k = 0; k < 5; k++) send(0, $urandom, 3'd0, 0, 8'h00);
        iv[0] = 0;
        bp_done = 1;
      end
    join_none
    idle(4);
    chk("bp_accepts", in_cnt[0] - base, 2);
    chk("bp_in_ready", irdy[0], 0);
    ordy[0] = 1;
    for (int t = 0; t < 60 && !bp_done; t++) idle(1);
    chk("bp_done", bp_done, 1);
    idle(4);

    // Asynchronous reset with two transactions in flight
    ordy[0] = 0;
    send(0, $urandom, 3'd0, 0, 8'h00);
    send(0, $urandom, 3'd2, 0, 8'h00);
    iv[0] = 0;
    chk("pre_rst_valid", ov[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", ov[0], 0);
    chk("rst_async_ready", irdy[0], 0);
    chk("rst_async_data", od[0], 0);
    q0.delete(); q1.delete();
    macc[0] = 8'h00; macc[1] = 8'h00;
    base = out_cnt[0];
    ordy[0] = 1;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    idle(5);
    chk("rst_dropped", out_cnt[0] - base, 0);
    chk("rst_release_ready", irdy[0], 1);
    send(0, 32'h0002, 3'd6, 1, 8'h02);
    iv[0] = 0;
    idle(4);

    // Throughput: 16 back-to-back with out_ready high
    lat_chk = 1; thr = 1;
    base = out_cnt[1];
    for (int k = 0; k < 16; k++) send(1, $urandom, 3'($urandom_range(0, 5)), 0, 8'h00);
    iv[1] = 0;
    idle(4);
    thr = 0; lat_chk = 0;
    chk("thr_count", out_cnt[1] - base, 16);

    // Random ops, random gaps, random backpressure
    for (int i = 0; i < 2; i++) begin
      rnd_en[i] = 1;
      repeat (150) begin
        send(i, $urandom, 3'($urandom_range(0, 7)), 0, 8'h00);
        if ($urandom_range(0, 3) == 0) begin
          iv[i] = 0;
          idle($urandom_range(1, 2));
        end
      end
      iv[i] = 0;
      rnd_en[i] = 0;
      idle(1);
      ordy[i] = 1;
      idle(6);
    end
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
